// File: rtl/cobra_mover.sv
// cobra_mover: snake head/body mover for the playfield grid.
// On each accepted step it moves the head one cell in the requested direction.
// A request that exactly reverses the last move is replaced by the last move.
// It shifts the body history, applies any pending growth, and sets a sticky
// flag on a wall or self collision. Every cycle it also answers a one-cell
// occupancy query for the renderer.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   cobra_dir  requested direction (00 up, 01 down, 10 left, 11 right)
//   step       one-cycle pulse: advance the snake once
//   grow       one-cycle pulse: the next applied step lengthens the snake
//   query_x/y  renderer query cell
//   query_hit  registered: the queried cell holds a live segment
//   head_x/y   current head cell
//   length     current live segment count
//   dead       sticky collision flag
//   step_done  one-cycle pulse after an accepted step
module cobra_mover #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int COORD_W   = 6,
  parameter int MAX_LEN   = 16,
  parameter int START_X   = 16,
  parameter int START_Y   = 12,
  parameter int START_LEN = 3,
  localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         cobra_dir,
  input  logic               step,
  input  logic               grow,
  input  logic [COORD_W-1:0] query_x,
  input  logic [COORD_W-1:0] query_y,
  output logic               query_hit,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [LEN_W-1:0]   length,
  output logic               dead,
  output logic               step_done
);

  localparam logic signed [COORD_W:0] GRID_W_S = (COORD_W + 1)'(GRID_W);
  localparam logic signed [COORD_W:0] GRID_H_S = (COORD_W + 1)'(GRID_H);

  logic [COORD_W-1:0] seg_x_r [MAX_LEN];
  logic [COORD_W-1:0] seg_y_r [MAX_LEN];
  logic [1:0]         cur_dir_r;
  logic               grow_pending_r;
  logic [LEN_W-1:0]   length_r;
  logic               dead_r;
  logic               step_done_r;
  logic               query_hit_r;

  logic [1:0]               eff_dir_s;
  logic signed [COORD_W:0]  dx_s;
  logic signed [COORD_W:0]  dy_s;
  logic signed [COORD_W:0]  nx_s;
  logic signed [COORD_W:0]  ny_s;
  logic [COORD_W-1:0]       new_x_s;
  logic [COORD_W-1:0]       new_y_s;
  logic                     wall_s;
  logic                     grow_eff_s;
  logic [LEN_W-1:0]         cmp_len_s;
  logic                     self_hit_s;
  logic                     q_hit_s;

  // Next-head computation, collision detection and occupancy query.
  always_comb begin
    eff_dir_s  = cobra_dir;
    dx_s       = '0;
    dy_s       = '0;
    self_hit_s = 1'b0;
    q_hit_s    = 1'b0;

    // Reverse of a direction differs only in bit 0 within the same axis.
    if (cobra_dir == {cur_dir_r[1], ~cur_dir_r[0]}) begin
      eff_dir_s = cur_dir_r;
    end else begin
      eff_dir_s = cobra_dir;
    end

    case (eff_dir_s)
      2'b00:   dy_s = -(COORD_W + 1)'(1);
      2'b01:   dy_s = (COORD_W + 1)'(1);
      2'b10:   dx_s = -(COORD_W + 1)'(1);
      2'b11:   dx_s = (COORD_W + 1)'(1);
      default: begin
        dx_s = '0;
        dy_s = '0;
      end
    endcase

    nx_s    = $signed({1'b0, seg_x_r[0]}) + dx_s;
    ny_s    = $signed({1'b0, seg_y_r[0]}) + dy_s;
    new_x_s = nx_s[COORD_W-1:0];
    new_y_s = ny_s[COORD_W-1:0];

    wall_s = (nx_s < $signed((COORD_W + 1)'(0))) || (nx_s >= GRID_W_S) ||
             (ny_s < $signed((COORD_W + 1)'(0))) || (ny_s >= GRID_H_S);

    // At full length growth is dropped, so the tail vacates as usual.
    grow_eff_s = (grow | grow_pending_r) && (length_r < LEN_W'(MAX_LEN));
    if (grow_eff_s) begin
      cmp_len_s = length_r;
    end else begin
      cmp_len_s = length_r - LEN_W'(1);
    end

    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < cmp_len_s) && (seg_x_r[i] == new_x_s) && (seg_y_r[i] == new_y_s)) begin
        self_hit_s = 1'b1;
      end else begin
        self_hit_s = self_hit_s;
      end
      if ((LEN_W'(i) < length_r) && (seg_x_r[i] == query_x) && (seg_y_r[i] == query_y)) begin
        q_hit_s = 1'b1;
      end else begin
        q_hit_s = q_hit_s;
      end
    end
  end

  // Snake state: segment history, direction, length, growth and death flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < START_LEN) begin
          seg_x_r[i] <= COORD_W'(START_X - i);
          seg_y_r[i] <= COORD_W'(START_Y);
        end else begin
          seg_x_r[i] <= '0;
          seg_y_r[i] <= '0;
        end
      end
      cur_dir_r      <= 2'b11;
      grow_pending_r <= 1'b0;
      length_r       <= LEN_W'(START_LEN);
      dead_r         <= 1'b0;
      step_done_r    <= 1'b0;
      query_hit_r    <= 1'b0;
    end else begin
      step_done_r <= 1'b0;
      query_hit_r <= q_hit_s;
      if (!dead_r) begin
        if (step) begin
          step_done_r <= 1'b1;
          if (wall_s || self_hit_s) begin
            dead_r <= 1'b1;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_r[i] <= seg_x_r[i-1];
              seg_y_r[i] <= seg_y_r[i-1];
            end
            seg_x_r[0]     <= new_x_s;
            seg_y_r[0]     <= new_y_s;
            cur_dir_r      <= eff_dir_s;
            grow_pending_r <= 1'b0;
            if (grow_eff_s) begin
              length_r <= length_r + LEN_W'(1);
            end else begin
              length_r <= length_r;
            end
          end
        end else if (grow) begin
          grow_pending_r <= 1'b1;
        end else begin
          grow_pending_r <= grow_pending_r;
        end
      end else begin
        dead_r <= dead_r;
      end
    end
  end

  assign head_x    = seg_x_r[0];
  assign head_y    = seg_y_r[0];
  assign length    = length_r;
  assign dead      = dead_r;
  assign step_done = step_done_r;
  assign query_hit = query_hit_r;

endmodule

// File: doc/cobra_mover.md
# cobra_mover

Consumer of the 2-bit `cobra_dir` code produced by the direction-input block. On each game `step` pulse it advances the snake head one cell on the playfield grid, shifts the body segment history, handles growth, and flags wall or self collision. It also answers single-cell occupancy queries for the VGA renderer.

## Interface
Parameters:
- `GRID_W`, 32: playfield width in cells; x range 0..GRID_W-1.
- `GRID_H`, 24: playfield height in cells; y range 0..GRID_H-1.
- `COORD_W`, 6: width of every x/y coordinate.
- `MAX_LEN`, 16: segment storage depth; maximum snake length.
- `START_X`, 16: reset x of the head.
- `START_Y`, 12: reset y of the head.
- `START_LEN`, 3: reset length. Requires 1 ≤ START_LEN ≤ MAX_LEN and START_LEN-1 ≤ START_X.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cobra_dir` in 2: requested direction. 00 = up (y-1), 01 = down (y+1), 10 = left (x-1), 11 = right (x+1).
- `step` in 1: one-cycle pulse; advance the snake once.
- `grow` in 1: one-cycle pulse; the next applied step lengthens the snake.
- `query_x` in COORD_W: renderer query x.
- `query_y` in COORD_W: renderer query y.
- `query_hit` out 1: registered; the queried cell holds a live segment.
- `head_x` out COORD_W: current head x.
- `head_y` out COORD_W: current head y.
- `length` out $clog2(MAX_LEN+1): current live segment count.
- `dead` out 1: sticky collision flag.
- `step_done` out 1: one-cycle pulse when a step has been processed.

## Operation
- State:
  - `seg[0..MAX_LEN-1]` holds (x,y) pairs; `seg[0]` is the head.
  - `cur_dir` holds the direction actually moved last.
  - `grow_pending` flag.
- Reset values:
  - `seg[i]` = (START_X-i, START_Y) for i < START_LEN; unused entries are 0.
  - `cur_dir` = 11; `length` = START_LEN; `head` = (START_X, START_Y).
  - `dead`, `step_done`, `query_hit`, `grow_pending` = 0.
- `grow` sets `grow_pending`. It is cleared when a step consumes it. `grow` and `step` in the same cycle: the grow applies to that step.
- Direction select on step: eff_dir = `cobra_dir`, unless `cobra_dir` is the exact reverse of `cur_dir` (00↔01, 10↔11). In that case eff_dir = `cur_dir`.
- New head = `seg[0]` moved one cell in eff_dir. Compute with COORD_W+1-bit signed arithmetic.
- Wall collision: new x < 0, new x ≥ GRID_W, new y < 0, or new y ≥ GRID_H. No wrap-around.
- Self collision: new head equals `seg[i]` for any i in 0..length-2 when not growing. Compare i in 0..length-1 when growing (tail does not vacate).
  - Growth is suppressed when length = MAX_LEN. In that case use the non-growing rule.
- On any collision:
  - `dead` <= 1.
  - `seg`, `length`, `cur_dir` unchanged.
  - `grow_pending` unchanged.
- If no collision:
  - `seg[i]` <= `seg[i-1]` for i ≥ 1; `seg[0]` <= new head; `cur_dir` <= eff_dir.
  - If growing and length < MAX_LEN: `length` +1.
  - `grow_pending` <= 0.
- While `dead` = 1, `step` and `grow` are ignored and no `step_done` is issued. Only `reset` clears `dead`.
- Query: `query_hit` = 1 iff (query_x, query_y) equals `seg[i]` for some i < length. Evaluation is every cycle, independent of `step`.

## Timing
- Step is applied at the clock edge where `step` = 1. From the following cycle, `head_x`, `head_y`, `length`, `dead` show the result.
- `step_done` is high for exactly the cycle after an accepted step, including a step that causes death. It is never high for an ignored step.
- `step` pulses are spaced ≥ 2 cycles; back-to-back `step` is undefined.
- `query_hit` latency is 1 cycle from `query_x`/`query_y`. The result reflects segment state at the sampling edge.
- `reset` asserted at any time (mid-step included) forces all reset values immediately, without waiting for a clock edge. The first step is accepted on the first edge after deassertion.

## Test plan
- Move right: reset, `cobra_dir`=11, 3 steps → head (19,12), length 3.
  - Query (17,12) → `query_hit`=1; query (16,12) → 0.
- Reversal rejected: reset, `cobra_dir`=10, 1 step → head (17,12), `cur_dir` stays right.
- Wall: reset, `cobra_dir`=00, 12 steps → head (16,0), `dead`=0.
  - 13th step → `dead`=1, head still (16,0), `step_done` pulses once.
  - A further step gives no `step_done` and no change.
- Grow: reset, `grow`+`step` in the same cycle with dir 11 → head (17,12), length 4.
  - (14,12) still hits on query.
- Self collision: reset, dir 11; grow+step twice → head (18,12), length 5.
  - Then steps with dir 00, 10, 01 → third step targets (17,12).
  - Result: `dead`=1, head stays (17,11).
- Async reset: after any scenario, pulse `reset` between clock edges.
  - All outputs return to reset values before the next edge, with `dead`=0 and length 3.
